// File: rtl/counter_nbit_sync_updown.sv
// -----------------------------------------------------------------------------
// counter_nbit_sync_updown
//
// Parametrised synchronous up/down modulo counter for the controller datapath.
// It counts over 0..MOD-1 and has an enable, a direction input, a synchronous
// clear, a clamped parallel load, a combinational terminal-count output and a
// registered wrap pulse. The legacy fixed 4-bit binary counter is the
// WIDTH=4, MOD=16 instance of this block.
//
// Parameters:
//   WIDTH     - counter width in bits (1..32)
//   modulus   - parameter MOD, q spans 0..MOD-1 (2..2**WIDTH)
//   RESET_VAL - value of q after clear (must be < MOD)
//
// Ports:
//   clk   in   rising-edge clock
//   clr_n in   asynchronous clear, active-low (q=RESET_VAL, wrap=0)
//   sclr  in   synchronous clear to RESET_VAL (highest edge priority)
//   load  in   synchronous parallel load of d, clamped to MOD-1
//   en    in   count enable
//   up    in   direction: 1 = increment, 0 = decrement
//   d     in   parallel load value [WIDTH]
//   q     out  registered count value [WIDTH]
//   tc    out  terminal count, combinational: en & (at limit for direction)
//   wrap  out  registered one-cycle pulse, a wrap occurred on the last edge
//
// Optional feature (macro COUNTER_SAT_EN):
//   defined     - saturating mode: counting past a limit holds q, wrap is 0
//   not defined - modulo wrap-around, wrap pulse active
// -----------------------------------------------------------------------------
module counter_nbit_sync_updown #(
    parameter int                WIDTH     = 4,
    parameter longint unsigned   MOD       = 64'd16,
    parameter int                RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             sclr,
    input  logic             load,
    input  logic             en,
    input  logic             up,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap
);

    // The modulus parameter is 64-bit so that 2**32 is representable when WIDTH = 32.
    localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(MOD - 64'd1);
    localparam logic [WIDTH-1:0] RST_VAL  = WIDTH'(RESET_VAL);
    localparam logic [WIDTH-1:0] ZERO_VAL = '0;
    localparam logic [WIDTH-1:0] ONE_VAL  = WIDTH'(32'd1);

    logic [WIDTH-1:0] q_r;
    logic             wrap_r;
    logic [WIDTH-1:0] q_nxt_s;
    logic             wrap_nxt_s;
    logic             at_max_s;
    logic             at_zero_s;

    // Limit detection on the current count.
    always_comb begin
        at_max_s  = (q_r == MAX_VAL);
        at_zero_s = (q_r == ZERO_VAL);
    end

    // Next-state selection: sclr > load > en > hold. The limit compare is
    // always applied, so the increment/decrement never relies on native
    // WIDTH-bit overflow and q can never reach MOD or beyond.
    always_comb begin
        q_nxt_s    = q_r;
        wrap_nxt_s = 1'b0;
        if (sclr) begin
            q_nxt_s = RST_VAL;
        end else if (load) begin
            if (d > MAX_VAL) begin
                q_nxt_s = MAX_VAL;
            end else begin
                q_nxt_s = d;
            end
        end else if (en) begin
            if (up) begin
                if (at_max_s) begin
`ifdef COUNTER_SAT_EN
                    q_nxt_s    = MAX_VAL;
`else
                    q_nxt_s    = ZERO_VAL;
                    wrap_nxt_s = 1'b1;
`endif
                end else begin
                    q_nxt_s = q_r + ONE_VAL;
                end
            end else begin
                if (at_zero_s) begin
`ifdef COUNTER_SAT_EN
                    q_nxt_s    = ZERO_VAL;
`else
                    q_nxt_s    = MAX_VAL;
                    wrap_nxt_s = 1'b1;
`endif
                end else begin
                    q_nxt_s = q_r - ONE_VAL;
                end
            end
        end else begin
            q_nxt_s = q_r;
        end
    end

    // Count and wrap registers; clr_n aborts anything in flight immediately.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            q_r    <= RST_VAL;
            wrap_r <= 1'b0;
        end else begin
            q_r    <= q_nxt_s;
            wrap_r <= wrap_nxt_s;
        end
    end

    // Terminal count is combinational so it can enable a cascaded stage on
    // the same edge; it deliberately ignores sclr and load.
    always_comb begin
        tc = en & ((up & at_max_s) | (~up & at_zero_s));
    end

    assign q    = q_r;
    assign wrap = wrap_r;

endmodule

// File: tb/tb_counter_nbit_sync_updown.sv
module tb_counter_nbit_sync_updown;

    logic       clk;
    logic       clr_n;
    logic       sclr;
    logic       load;
    logic       en;
    logic       up;
    logic [3:0] d;
    logic [3:0] q;
    logic       tc;
    logic       wrap;

    logic       c_en;
    logic [3:0] c0_q;
    logic [3:0] c1_q;
    logic       c0_tc;
    logic       c1_tc;
    logic       c0_wrap;
    logic       c1_wrap;

    int n_vec;
    int n_err;

    counter_nbit_sync_updown #(.WIDTH(4), .MOD(64'd10), .RESET_VAL(3)) dut (
        .clk(clk), .clr_n(clr_n), .sclr(sclr), .load(load), .en(en), .up(up),
        .d(d), .q(q), .tc(tc), .wrap(wrap)
    );

    counter_nbit_sync_updown #(.WIDTH(4), .MOD(64'd10), .RESET_VAL(0)) u_lo (
        .clk(clk), .clr_n(clr_n), .sclr(1'b0), .load(1'b0), .en(c_en), .up(1'b1),
        .d(4'd0), .q(c0_q), .tc(c0_tc), .wrap(c0_wrap)
    );

    counter_nbit_sync_updown #(.WIDTH(4), .MOD(64'd10), .RESET_VAL(0)) u_hi (
        .clk(clk), .clr_n(clr_n), .sclr(1'b0), .load(1'b0), .en(c0_tc), .up(1'b1),
        .d(4'd0), .q(c1_q), .tc(c1_tc), .wrap(c1_wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        clr_n = 1'b1; sclr = 1'b0; load = 1'b0; en = 1'b0; up = 1'b1; d = 4'd0;
        c_en  = 1'b0;

        // Asynchronous clear between edges (first posedge is at t=5).
        #3;
        clr_n = 1'b0;
        #1;
        chk("rst_q_async", q, 32'd3);
        chk("rst_wrap_async", wrap, 32'd0);
        tick();
        tick();
        chk("rst_q_held", q, 32'd3);
        clr_n = 1'b1;
        tick();
        chk("rst_release_hold", q, 32'd3);
        en = 1'b1; up = 1'b1;
        tick();
        chk("first_count", q, 32'd4);

`ifndef COUNTER_SAT_EN
        // Up wrap from 8: 9, 0, 1.
        en = 1'b0; load = 1'b1; d = 4'd8;
        tick();
        chk("load8", q, 32'd8);
        load = 1'b0; en = 1'b1; up = 1'b1;
        #1;
        chk("up_tc_at8", tc, 32'd0);
        tick();
        chk("up_q9", q, 32'd9);
        chk("up_tc_at9", tc, 32'd1);
        chk("up_wrap_at9", wrap, 32'd0);
        tick();
        chk("up_q0", q, 32'd0);
        chk("up_wrap_at0", wrap, 32'd1);
        chk("up_tc_at0", tc, 32'd0);
        tick();
        chk("up_q1", q, 32'd1);
        chk("up_wrap_at1", wrap, 32'd0);

        // Down wrap from 1: 0, 9, 8.
        up = 1'b0;
        #1;
        chk("dn_tc_at1", tc, 32'd0);
        tick();
        chk("dn_q0", q, 32'd0);
        chk("dn_tc_at0", tc, 32'd1);
        chk("dn_wrap_at0", wrap, 32'd0);
        tick();
        chk("dn_q9", q, 32'd9);
        chk("dn_wrap_at9", wrap, 32'd1);
        chk("dn_tc_at9", tc, 32'd0);
        tick();
        chk("dn_q8", q, 32'd8);
        chk("dn_wrap_at8", wrap, 32'd0);

        // Direction change takes effect on the same edge.
        up = 1'b1;
        tick();
        chk("dir_change", q, 32'd9);
`else
        // Saturating mode: up from 8 holds at 9, wrap stays 0.
        en = 1'b0; load = 1'b1; d = 4'd8;
        tick();
        chk("sat_load8", q, 32'd8);
        load = 1'b0; en = 1'b1; up = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("sat_up_q", q, 32'd9);
            chk("sat_up_wrap", wrap, 32'd0);
            chk("sat_up_tc", tc, 32'd1);
        end
        up = 1'b0;
        tick();
        chk("sat_dn_q8", q, 32'd8);
        load = 1'b1; d = 4'd0;
        tick();
        load = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("sat_dn_q0", q, 32'd0);
            chk("sat_dn_wrap", wrap, 32'd0);
        end
`endif

        // Priority: sclr beats load and en; then load clamps and beats count.
        en = 1'b0; load = 1'b1; d = 4'd5;
        tick();
        chk("load5", q, 32'd5);
        sclr = 1'b1; load = 1'b1; d = 4'd7; en = 1'b1; up = 1'b1;
        tick();
        chk("sclr_prio", q, 32'd3);
        chk("sclr_wrap", wrap, 32'd0);
        sclr = 1'b0; load = 1'b1; d = 4'd12;
        tick();
        chk("clamp12", q, 32'd9);
        chk("clamp_wrap", wrap, 32'd0);
        #1;
        chk("tc_ignores_load", tc, 32'd1);
        d = 4'd15;
        tick();
        chk("clamp15_over_wrap", q, 32'd9);
        chk("load_over_wrap", wrap, 32'd0);

        // Asynchronous clear mid-operation.
        load = 1'b0; en = 1'b1; up = 1'b1; d = 4'd0;
        tick();
`ifndef COUNTER_SAT_EN
        chk("pre_abort_q", q, 32'd0);
        chk("pre_abort_wrap", wrap, 32'd1);
`else
        chk("pre_abort_q", q, 32'd9);
`endif
        #2;
        clr_n = 1'b0;
        #1;
        chk("abort_q", q, 32'd3);
        chk("abort_wrap", wrap, 32'd0);
        tick();
        clr_n = 1'b1; en = 1'b0;
        tick();
        chk("abort_hold", q, 32'd3);

`ifndef COUNTER_SAT_EN
        // BCD cascade: low stage counts, high stage enabled by low tc.
        chk("bcd_start", {c1_q, c0_q}, 32'h00);
        c_en = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            tick();
            chk("bcd_count", {c1_q, c0_q}, {24'd0, 4'((i % 100) / 10), 4'(i % 10)});
            chk("bcd_hi_wrap", c1_wrap, (i == 100) ? 32'd1 : 32'd0);
        end
        for (int i = 1; i <= 37; i++) begin
            tick();
        end
        chk("bcd_37", {c1_q, c0_q}, 32'h37);
        c_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bcd_hold", {c1_q, c0_q}, 32'h37);
            chk("bcd_hold_tc", c0_tc, 32'd0);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/counter_nbit_sync_updown.md
Name: counter_nbit_sync_updown

Overview:
Parametrised synchronous up/down modulo counter. It is the next-generation counting primitive for the controller, with configurable width and modulus. It adds count enable, direction, synchronous clear, parallel load, terminal-count and wrap outputs. It is used as the general sequencing/timing counter in the controller datapath; the fixed 4-bit binary counter becomes the WIDTH=4, MOD=16 case.

Parameters:
WIDTH, 4, counter width in bits; legal range 1..32.
MOD, 16, count modulus; q spans 0..MOD-1; legal range 2..2**WIDTH.
RESET_VAL, 0, value of q after async reset; must be < MOD.

Ports:
clk  input  1  rising-edge clock
clr_n  input  1  asynchronous clear, active-low
sclr  input  1  synchronous clear to RESET_VAL
load  input  1  synchronous parallel load of d
en  input  1  count enable
up  input  1  direction: 1 = increment, 0 = decrement
d  input  WIDTH  parallel load value
q  output  WIDTH  registered count value
tc  output  1  terminal count, combinational
wrap  output  1  registered one-cycle pulse: a wrap occurred on the previous edge

Behaviour:
- Reset: clr_n=0 forces q=RESET_VAL and wrap=0 immediately, independent of clk. It is held while clr_n is low. Release is synchronous to the next clk edge, and counting starts at that edge.
- Next-state priority on each rising edge: sclr > load > en > hold.
- sclr=1: q <= RESET_VAL, wrap <= 0.
- load=1 (sclr=0): q <= d if d <= MOD-1, else q <= MOD-1 (clamped). wrap <= 0.
- en=1, up=1: q <= q+1. If q == MOD-1, then q <= 0 and wrap <= 1.
- en=1, up=0: q <= q-1. If q == 0, then q <= MOD-1 and wrap <= 1.
- en=0: q holds, wrap <= 0.
- wrap is high for exactly one cycle per wrap event. Consecutive wraps (e.g. MOD=2 counting every cycle) keep wrap high on each of those cycles.
- tc = en & ((up & q==MOD-1) | (~up & q==0)). It has zero latency and is usable as a cascade enable for the next stage. tc ignores sclr and load.
- Out-of-range q cannot occur after reset, because all paths keep q < MOD.
- Arithmetic: the WIDTH-bit increment/decrement never uses native overflow. The modulus compare is always applied, so when MOD < 2**WIDTH values >= MOD are never produced.
- Direction change mid-count takes effect on the same edge. No pipeline and no latency beyond one register.
- Async reset asserted mid-operation aborts any load/count in flight. Nothing is retained.

Optional Feature:
Macro COUNTER_SAT_EN.
- Defined: saturating mode. Counting up at q == MOD-1, or down at q == 0, holds q; wrap is tied to 0. tc keeps the same definition and serves as an "at limit" indicator. sclr and load are unchanged.
- Not defined: modulo wrap-around as described in Behaviour; wrap is active.

Test Plan:
- Reset: WIDTH=4, MOD=10, RESET_VAL=3; assert clr_n=0 between clock edges -> q=3 and wrap=0 without waiting for an edge; release -> q holds 3 until the first en=1 edge.
- Up wrap: MOD=10, en=1, up=1 from q=8 -> q sequence 9,0,1; tc=1 only while q=9; wrap=1 only in the cycle where q=0.
- Down wrap: MOD=10, en=1, up=0 from q=1 -> q sequence 0,9,8; tc=1 only while q=0; wrap=1 only in the cycle where q=9.
- Priority and clamp: at q=5, sclr=1, load=1, d=7, en=1 on one edge -> q=RESET_VAL; next edge load=1, d=12, en=1 -> q=9 (clamped), wrap=0.
- Hold and cascade: two instances, the second enabled by the first's tc, WIDTH=4, MOD=10 -> a BCD 00..99 sequence; the second stage increments only on 9->0 of the first; en=0 for 5 cycles -> both hold.
- COUNTER_SAT_EN defined: MOD=10, up=1 from q=8 for 4 edges -> q=9,9,9,9 and wrap stays 0; then up=0 -> q=8.
